// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its decade cells.
package bcd_down_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Non-BCD nibbles saturate to 9 rather than wrapping.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > MAX_DIGIT) ? MAX_DIGIT : d;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One BCD decade of the countdown timer: clamped load, decrement with 0 -> 9 wrap.
module bcd_down_digit
    import bcd_down_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    input  logic               dec_en,
    output logic [DIGIT_W-1:0] q,
    output logic               is_zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= clamp_digit(d);
        end else if (dec_en) begin
            q <= (q == '0) ? MAX_DIGIT : q - 1'b1;
        end
    end

    assign is_zero = (q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-decade BCD countdown timer with start/pause control and a one-cycle done pulse.
// Optional auto-reload on expiry is enabled by defining BCD_TIMER_RELOAD_EN.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_val,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    tick,
    output logic [4*DIGITS-1:0]     count,
    output logic                    running,
    output logic                    zero,
    output logic                    done,
    output state_t                  state
);

    localparam logic [4*DIGITS-1:0] COUNT_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

    state_t                state_q;
    state_t                state_d;
    logic [DIGITS-1:0]     digit_zero;
    logic [DIGITS:0]       lower_zero;
    logic                  dec_glob;
    logic                  expire;
    logic                  reload_hit;
    logic                  digit_load;
    logic [4*DIGITS-1:0]   digit_d;

`ifdef BCD_TIMER_RELOAD_EN
    logic [4*DIGITS-1:0]   reload_q;
    logic [4*DIGITS-1:0]   load_clamped;

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_clamped;
        end
    end

    // A zero reload value falls back to the plain expire-and-stop behaviour.
    assign reload_hit = expire && (reload_q != '0);
    assign digit_load = load || reload_hit;
    assign digit_d    = load ? load_val : reload_q;
`else
    assign reload_hit = 1'b0;
    assign digit_load = load;
    assign digit_d    = load_val;
`endif

    assign lower_zero[0] = 1'b1;

    // Decade i borrows only when every lower decade is already 0.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .load    (digit_load),
            .d       (digit_d[4*i +: 4]),
            .dec_en  (dec_glob && lower_zero[i]),
            .q       (count[4*i +: 4]),
            .is_zero (digit_zero[i])
        );
        assign lower_zero[i+1] = lower_zero[i] && digit_zero[i];
    end

    assign zero     = lower_zero[DIGITS];
    assign dec_glob = (state_q == ST_RUN) && tick && !pause && !load;
    assign expire   = dec_glob && (count == COUNT_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= expire;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (start && !zero) state_d = ST_RUN;
                ST_RUN: begin
                    if (pause)                     state_d = ST_PAUSED;
                    else if (expire && !reload_hit) state_d = ST_EXPIRED;
                end
                ST_PAUSED:  if (start) state_d = ST_RUN;
                ST_EXPIRED: state_d = ST_EXPIRED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state_q == ST_RUN);
        state   = state_q;
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed testbench for bcd_down_timer (DIGITS=3); honours BCD_TIMER_RELOAD_EN.
module tb_bcd_down_timer;
    import bcd_down_timer_pkg::*;

    localparam int DIGITS = 3;
    localparam int W = 4 * DIGITS;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic         tick;
    logic [W-1:0] count;
    logic         running;
    logic         zero;
    logic         done;
    state_t       state;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick     (tick),
        .count    (count),
        .running  (running),
        .zero     (zero),
        .done     (done),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One clock with the given controls; outputs are valid on return.
    task automatic cycle(input logic ld, input logic [W-1:0] lv, input logic st,
                         input logic ps, input logic tk);
        load = ld; load_val = lv; start = st; pause = ps; tick = tk;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] c, input logic r,
                             input logic d, input state_t s);
        check_eq({tag, "_count"},   32'(count),   32'(c));
        check_eq({tag, "_running"}, 32'(running), 32'(r));
        check_eq({tag, "_done"},    32'(done),    32'(d));
        check_eq({tag, "_state"},   32'(state),   32'(s));
    endtask

    logic   reloads;
    state_t expired_state;

    initial begin
`ifdef BCD_TIMER_RELOAD_EN
        reloads = 1'b1;
        expired_state = ST_RUN;
`else
        reloads = 1'b0;
        expired_state = ST_EXPIRED;
`endif
        reset = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        #2;
        check_out("reset", 12'h000, 1'b0, 1'b0, ST_IDLE);
        check_eq("reset_zero", 32'(zero), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // 25 ticks from 025: one decrement per tick, expiry on the 25th
        cycle(1'b1, 12'h025, 1'b0, 1'b0, 1'b0);
        check_out("load25", 12'h025, 1'b0, 1'b0, ST_IDLE);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_out("start25", 12'h025, 1'b1, 1'b0, ST_RUN);
        for (int i = 1; i <= 25; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            if (i < 25) begin
                check_out($sformatf("tick25_%0d", i), to_bcd(25 - i), 1'b1, 1'b0, ST_RUN);
            end else begin
                check_out("tick25_last", reloads ? 12'h025 : 12'h000, reloads, 1'b1, expired_state);
                check_eq("tick25_zero", 32'(zero), 32'(!reloads));
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_out("exp_start", reloads ? 12'h025 : 12'h000, reloads, 1'b0, expired_state);

        // Borrow across two decades
        cycle(1'b1, 12'h100, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_out("borrow1", 12'h099, 1'b1, 1'b0, ST_RUN);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_out("borrow2", 12'h098, 1'b1, 1'b0, ST_RUN);

        // load wins over start/tick while running
        cycle(1'b1, 12'h042, 1'b1, 1'b0, 1'b1);
        check_out("load_prio", 12'h042, 1'b0, 1'b0, ST_IDLE);

        // Pause behaviour
        cycle(1'b1, 12'h005, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_out("pause_pre", 12'h003, 1'b1, 1'b0, ST_RUN);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check_out("pause_tick", 12'h003, 1'b0, 1'b0, ST_PAUSED);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_out("paused_ticks", 12'h003, 1'b0, 1'b0, ST_PAUSED);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_out("resume", 12'h003, 1'b1, 1'b0, ST_RUN);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_out("resume_t2", 12'h001, 1'b1, 1'b0, ST_RUN);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_out("resume_t3", reloads ? 12'h005 : 12'h000, reloads, 1'b1, expired_state);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("done_one_cycle", 32'(done), 32'd0);

        // pause beats start and tick in RUN
        cycle(1'b1, 12'h007, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check_out("pause_wins", 12'h007, 1'b0, 1'b0, ST_PAUSED);

        // Clamp of non-BCD nibbles, and start ignored at zero
        cycle(1'b1, 12'h0A3, 1'b0, 1'b0, 1'b0);
        check_out("clamp_a3", 12'h093, 1'b0, 1'b0, ST_IDLE);
        cycle(1'b1, 12'hFBC, 1'b0, 1'b0, 1'b0);
        check_out("clamp_fbc", 12'h999, 1'b0, 1'b0, ST_IDLE);
        cycle(1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_out("start_at_zero", 12'h000, 1'b0, 1'b0, ST_IDLE);
        check_eq("start_at_zero_zero", 32'(zero), 32'd1);

        // Asynchronous reset mid-run
        cycle(1'b1, 12'h015, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_out("pre_reset", 12'h014, 1'b1, 1'b0, ST_RUN);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", 12'h000, 1'b0, 1'b0, ST_IDLE);
        check_eq("async_reset_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_out("post_reset_start", 12'h000, 1'b0, 1'b0, ST_IDLE);

`ifdef BCD_TIMER_RELOAD_EN
        // Auto-reload: two full periods of 3 ticks each
        cycle(1'b1, 12'h003, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            check_out($sformatf("reload_p%0d_t1", p), 12'h002, 1'b1, 1'b0, ST_RUN);
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            check_out($sformatf("reload_p%0d_t2", p), 12'h001, 1'b1, 1'b0, ST_RUN);
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            check_out($sformatf("reload_p%0d_t3", p), 12'h003, 1'b1, 1'b1, ST_RUN);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
